// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : bcd_pkg
//  Brief   : Shared types, constants and elaboration helpers for the
//            sequential binary-to-BCD converter.
//  Revision: 1.0  initial release
// ============================================================================
package bcd_pkg;

    // Converter FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Bits per BCD digit
    localparam int BCD_DIGIT_W     = 4;
    // Digits at or above this value get +3 before the shift
    localparam int BCD_ADD3_THRESH = 5;

    // Shift counter width: must hold the values 0..bin_w
    function automatic int cnt_w(input int bin_w);
        return $clog2(bin_w + 1);
    endfunction

    // True when 'digits' decimal digits can represent every bin_w-bit value
    function automatic bit digits_ok(input int bin_w, input int digits);
        longint unsigned v_cap;
        longint unsigned v_max;
        v_max = (64'd1 << bin_w) - 64'd1;
        v_cap = 64'd1;
        for (int i = 0; i < digits; i++) begin
            if (v_cap <= v_max) begin
                v_cap = v_cap * 64'd10;
            end
        end
        return (v_cap > v_max);
    endfunction

endpackage : bcd_pkg
`default_nettype wire

// File: rtl/bcd_add3_digit.sv
`default_nettype none
// ============================================================================
//  Module  : bcd_add3_digit
//  Brief   : Combinational shift-and-add-3 correction for one BCD digit:
//            digits 5..9 get +3 so the following left shift carries into
//            the next decade correctly.
//  Revision: 1.0  initial release
// ============================================================================
module bcd_add3_digit
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] i_digit,
    output logic [BCD_DIGIT_W-1:0] o_digit
);

    // Digits 10..15 never reach this stage, so the 4-bit sum cannot overflow
    always_comb begin
        o_digit = i_digit;
        if (i_digit >= BCD_DIGIT_W'(BCD_ADD3_THRESH)) begin
            o_digit = i_digit + BCD_DIGIT_W'(3);
        end
    end

endmodule : bcd_add3_digit
`default_nettype wire

// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module  : bin_to_bcd_seq
//  Brief   : Sequential binary-to-BCD converter, one bit per clock using
//            shift-and-add-3. Start/done handshake; result held stable
//            between conversions. Feeds the BCD-to-Excess-3 coder.
//  Revision: 1.0  initial release
// ============================================================================
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [BIN_W-1:0]              bin_in,
    output logic                          busy,
    output logic                          done,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out
);

    localparam int c_WORK_W = BCD_DIGIT_W * DIGITS;
    localparam int c_CNT_W  = cnt_w(BIN_W);

    // Refuse to build a converter whose digit count cannot hold the operand
    if (!digits_ok(BIN_W, DIGITS)) begin : g_digits_check
        $fatal(1, "bin_to_bcd_seq: DIGITS too small for BIN_W");
    end

    state_t                r_state;
    state_t                w_state_nxt;
    logic [BIN_W-1:0]      r_sreg;
    logic [c_WORK_W-1:0]   r_work;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [c_WORK_W-1:0]   r_bcd;

    logic [c_WORK_W-1:0]       w_work_adj;
    logic [c_WORK_W+BIN_W-1:0] w_cat;
    logic [c_WORK_W-1:0]       w_work_nxt;
    logic [BIN_W-1:0]          w_sreg_nxt;
    logic                      w_last;
    logic                      w_load;
    logic                      w_shift;
    logic                      w_capture;

    // One add-3 corrector per decade of the working register
    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        bcd_add3_digit u_add3 (
            .i_digit (r_work[k*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .o_digit (w_work_adj[k*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // Corrected digits and remaining operand bits shift left as one word
    assign w_cat      = {w_work_adj, r_sreg} << 1;
    assign w_work_nxt = w_cat[c_WORK_W+BIN_W-1:BIN_W];
    assign w_sreg_nxt = w_cat[BIN_W-1:0];
    assign w_last     = (r_cnt == c_CNT_W'(BIN_W - 1));
    assign bcd_out    = r_bcd;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, datapath controls and status decode
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_capture   = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy    = 1'b1;
                w_shift = 1'b1;
                if (w_last) begin
                    w_capture   = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = SHIFT;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Operand/work shift registers, bit counter and held result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sreg <= '0;
            r_work <= '0;
            r_cnt  <= '0;
            r_bcd  <= '0;
        end else begin
            if (w_load) begin
                r_sreg <= bin_in;
                r_work <= '0;
                r_cnt  <= '0;
            end else if (w_shift) begin
                r_sreg <= w_sreg_nxt;
                r_work <= w_work_nxt;
                r_cnt  <= r_cnt + c_CNT_W'(1);
            end
            if (w_capture) begin
                r_bcd <= w_work_nxt;
            end
        end
    end

endmodule : bin_to_bcd_seq
`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module  : tb_bin_to_bcd_seq
//  Brief   : Self-checking bench for bin_to_bcd_seq (BIN_W=8, DIGITS=3),
//            reference results computed by decimal arithmetic.
//  Revision: 1.0  initial release
// ============================================================================
module tb_bin_to_bcd_seq;

    localparam int BIN_W  = 8;
    localparam int DIGITS = 3;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        start  = 1'b0;
    logic [7:0]  bin_in = 8'd0;
    logic        busy;
    logic        done;
    logic [11:0] bcd_out;

    int n_tests = 0;
    int n_fail  = 0;

    bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Decimal digits of v, units first
    function automatic logic [11:0] ref_bcd(input int v);
        logic [11:0] r;
        int          rem;
        r   = '0;
        rem = v;
        for (int k = 0; k < DIGITS; k++) begin
            r[4*k +: 4] = 4'(rem % 10);
            rem         = rem / 10;
        end
        return r;
    endfunction

    // Drive one conversion; report latency (edges after acceptance) and result
    task automatic run_conv(input logic [7:0] v, output int lat,
                            output logic [11:0] res, output bit timeout,
                            output bit busy_ok, output bit stable_ok);
        logic [11:0] prev;
        @(negedge clk);
        start  = 1'b1;
        bin_in = v;
        prev   = bcd_out;
        @(posedge clk);
        @(negedge clk);
        start     = 1'b0;
        bin_in    = 8'($urandom);
        lat       = 0;
        timeout   = 1'b1;
        busy_ok   = 1'b1;
        stable_ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) begin
                timeout = 1'b0;
                break;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (bcd_out !== prev) stable_ok = 1'b0;
            @(posedge clk);
            lat++;
            @(negedge clk);
            bin_in = 8'($urandom);
        end
        res = bcd_out;
    endtask

    task automatic test_reset();
        #2;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_tests++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_tests++;
        if (bcd_out !== 12'h000) begin n_fail++; $display("FAIL reset_bcd: got %h want 000", bcd_out); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        int          vals[4] = '{0, 255, 99, 200};
        int          lat;
        logic [11:0] res;
        bit          to, bok, sok;
        foreach (vals[i]) begin
            run_conv(8'(vals[i]), lat, res, to, bok, sok);
            n_tests++;
            if (to) begin n_fail++; $display("FAIL dir_timeout: v=%0d no done within 40 cycles", vals[i]); end
            n_tests++;
            if (res !== ref_bcd(vals[i])) begin n_fail++; $display("FAIL dir_value: v=%0d got %h want %h", vals[i], res, ref_bcd(vals[i])); end
            n_tests++;
            if (lat !== BIN_W) begin n_fail++; $display("FAIL dir_latency: v=%0d got %0d want %0d", vals[i], lat, BIN_W); end
            n_tests++;
            if (!bok) begin n_fail++; $display("FAIL dir_busy: v=%0d busy dropped got 0 want 1", vals[i]); end
            n_tests++;
            if (!sok) begin n_fail++; $display("FAIL dir_stable: v=%0d bcd_out changed while busy got 1 want 0", vals[i]); end
            @(negedge clk);
            n_tests++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL dir_after_done: v=%0d got done=%b busy=%b want 0 0", vals[i], done, busy);
            end
        end
    endtask

    task automatic test_ignore_start();
        int          n_done  = 0;
        int          done_at = -1;
        bit          gap     = 1'b0;
        logic [11:0] res     = '0;
        @(negedge clk);
        start  = 1'b1;
        bin_in = 8'd42;
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
        bin_in = 8'($urandom);
        for (int i = 0; i < 14; i++) begin
            if (done === 1'b1) begin
                n_done++;
                done_at = i;
                res     = bcd_out;
            end else if (n_done == 0 && busy !== 1'b1) begin
                gap = 1'b1;
            end
            if (i == 2) begin
                start  = 1'b1;
                bin_in = 8'd7;
            end else if (i == 3) begin
                start  = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
        end
        n_tests++;
        if (n_done !== 1) begin n_fail++; $display("FAIL ign_done_count: got %0d want 1", n_done); end
        n_tests++;
        if (res !== 12'h042) begin n_fail++; $display("FAIL ign_value: got %h want 042", res); end
        n_tests++;
        if (done_at !== BIN_W) begin n_fail++; $display("FAIL ign_latency: got %0d want %0d", done_at, BIN_W); end
        n_tests++;
        if (gap) begin n_fail++; $display("FAIL ign_busy: busy gap got 1 want 0"); end
    endtask

    task automatic test_back_to_back();
        int          n_done = 0;
        int          t[2]   = '{-1, -1};
        logic [11:0] r[2]   = '{12'h0, 12'h0};
        bit          idle   = 1'b0;
        @(negedge clk);
        start  = 1'b1;
        bin_in = 8'd17;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) begin
                t[n_done] = i;
                r[n_done] = bcd_out;
                n_done++;
                if (n_done == 2) begin
                    start = 1'b0;
                    break;
                end
                bin_in = 8'd128;
            end else begin
                if (busy !== 1'b1) idle = 1'b1;
                bin_in = 8'($urandom);
            end
            @(posedge clk);
            @(negedge clk);
        end
        start = 1'b0;
        n_tests++;
        if (n_done !== 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d want 2", n_done); end
        n_tests++;
        if (r[0] !== 12'h017) begin n_fail++; $display("FAIL b2b_first: got %h want 017", r[0]); end
        n_tests++;
        if (r[1] !== 12'h128) begin n_fail++; $display("FAIL b2b_second: got %h want 128", r[1]); end
        n_tests++;
        if (t[1] - t[0] !== BIN_W + 1) begin n_fail++; $display("FAIL b2b_spacing: got %0d want %0d", t[1] - t[0], BIN_W + 1); end
        n_tests++;
        if (idle) begin n_fail++; $display("FAIL b2b_no_idle: idle cycle got 1 want 0"); end
    endtask

    task automatic test_async_reset();
        int          lat;
        logic [11:0] res;
        bit          to, bok, sok;
        bit          saw_done = 1'b0;
        run_conv(8'd255, lat, res, to, bok, sok);
        n_tests++;
        if (res !== 12'h255) begin n_fail++; $display("FAIL arst_pre: got %h want 255", res); end
        @(negedge clk);
        start  = 1'b1;
        bin_in = 8'($urandom);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL arst_busy: got %b want 0", busy); end
        n_tests++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL arst_done: got %b want 0", done); end
        n_tests++;
        if (bcd_out !== 12'h000) begin n_fail++; $display("FAIL arst_bcd: got %h want 000", bcd_out); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done !== 1'b0) saw_done = 1'b1;
        end
        n_tests++;
        if (saw_done) begin n_fail++; $display("FAIL arst_no_done: got done pulse want none"); end
        rst_n = 1'b1;
        run_conv(8'd63, lat, res, to, bok, sok);
        n_tests++;
        if (res !== 12'h063 || to) begin n_fail++; $display("FAIL arst_post: got %h timeout=%b want 063", res, to); end
        n_tests++;
        if (lat !== BIN_W) begin n_fail++; $display("FAIL arst_latency: got %0d want %0d", lat, BIN_W); end
    endtask

    task automatic test_exhaustive();
        int          lat;
        logic [11:0] res;
        bit          to, bok, sok;
        bit          bad_digit;
        for (int v = 0; v < 256; v++) begin
            run_conv(8'(v), lat, res, to, bok, sok);
            bad_digit = 1'b0;
            for (int k = 0; k < DIGITS; k++) begin
                if (res[4*k +: 4] > 4'd9) bad_digit = 1'b1;
            end
            n_tests++;
            if (to || res !== ref_bcd(v)) begin n_fail++; $display("FAIL exh_value: v=%0d got %h timeout=%b want %h", v, res, to, ref_bcd(v)); end
            n_tests++;
            if (bad_digit) begin n_fail++; $display("FAIL exh_digit: v=%0d got %h want all digits <= 9", v, res); end
            n_tests++;
            if (lat !== BIN_W) begin n_fail++; $display("FAIL exh_latency: v=%0d got %0d want %0d", v, lat, BIN_W); end
            n_tests++;
            if (!bok || !sok) begin n_fail++; $display("FAIL exh_status: v=%0d busy_ok=%b stable_ok=%b want 1 1", v, bok, sok); end
        end
    endtask

    task automatic test_random();
        int          lat;
        int          v;
        logic [11:0] res;
        bit          to, bok, sok;
        for (int n = 0; n < 40; n++) begin
            v = int'($urandom_range(0, 255));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_conv(8'(v), lat, res, to, bok, sok);
            n_tests++;
            if (to || res !== ref_bcd(v) || lat !== BIN_W) begin
                n_fail++;
                $display("FAIL rnd_conv: v=%0d got %h lat=%0d timeout=%b want %h lat=%0d", v, res, lat, to, ref_bcd(v), BIN_W);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_back_to_back();
        test_async_reset();
        test_exhaustive();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_bin_to_bcd_seq
`default_nettype wire
